// File: rtl/fusion_pkg.sv
// Shared widths and line-state encoding for the pixel-fusion pipeline stages.
package fusion_pkg;

    localparam int PIXEL_DATA_W_DEF = 8;
    localparam int DETAIL_LUT_W_DEF = 3;
    localparam int GRAD_SHIFT_DEF   = 4;
    localparam int DATA_LUT_W       = PIXEL_DATA_W_DEF + DETAIL_LUT_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } line_state_t;

endpackage

// File: rtl/detail_quant.sv
// Absolute difference of two pixels, shifted and saturated to a detail index.
// DETAIL_GRAD_SMOOTH_EN adds a rounded average with the previous gradient.
module detail_quant
    import fusion_pkg::*;
#(
    parameter int PIXEL_DATA_W = PIXEL_DATA_W_DEF,
    parameter int DETAIL_LUT_W = DETAIL_LUT_W_DEF,
    parameter int GRAD_SHIFT   = GRAD_SHIFT_DEF
) (
    input  logic [PIXEL_DATA_W-1:0] a,
    input  logic [PIXEL_DATA_W-1:0] b,
`ifdef DETAIL_GRAD_SMOOTH_EN
    input  logic [PIXEL_DATA_W-1:0] g_last,
    output logic [PIXEL_DATA_W-1:0] g_used,
`endif
    output logic [DETAIL_LUT_W-1:0] detail
);

    localparam logic [PIXEL_DATA_W-1:0] DETAIL_MAX = PIXEL_DATA_W'((1 << DETAIL_LUT_W) - 1);

    logic [PIXEL_DATA_W-1:0] grad;
    logic [PIXEL_DATA_W-1:0] g_eff;
    logic [PIXEL_DATA_W-1:0] shifted;

    assign grad = (a >= b) ? (a - b) : (b - a);

`ifdef DETAIL_GRAD_SMOOTH_EN
    // One extra bit keeps the rounded sum from wrapping before the halving.
    logic [PIXEL_DATA_W:0] g_sum;
    assign g_sum  = {1'b0, grad} + {1'b0, g_last} + {{PIXEL_DATA_W{1'b0}}, 1'b1};
    assign g_used = PIXEL_DATA_W'(g_sum >> 1);
    assign g_eff  = g_used;
`else
    assign g_eff  = grad;
`endif

    assign shifted = g_eff >> GRAD_SHIFT;
    assign detail  = (shifted > DETAIL_MAX) ? DETAIL_MAX[DETAIL_LUT_W-1:0]
                                            : shifted[DETAIL_LUT_W-1:0];

endmodule

// File: rtl/detail_lut_index.sv
// Builds the {pixel, horizontal detail} LUT address with line framing and edge replication.
// Optional gradient smoothing: define DETAIL_GRAD_SMOOTH_EN.
module detail_lut_index
    import fusion_pkg::*;
#(
    parameter int PIXEL_DATA_W = PIXEL_DATA_W_DEF,
    parameter int DETAIL_LUT_W = DETAIL_LUT_W_DEF,
    parameter int GRAD_SHIFT   = GRAD_SHIFT_DEF
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [PIXEL_DATA_W-1:0]              pix_data_i,
    input  logic                                 pix_valid_i,
    input  logic                                 pix_sol_i,
    input  logic                                 pix_eol_i,
    output logic                                 pix_ready_o,
    output logic [PIXEL_DATA_W+DETAIL_LUT_W-1:0] data_lut_o,
    output logic                                 lut_valid_o,
    output logic                                 lut_sol_o,
    output logic                                 lut_eol_o
);

    line_state_t             state;
    logic [PIXEL_DATA_W-1:0] p_prev;
    logic [PIXEL_DATA_W-1:0] p_cur;
    logic [PIXEL_DATA_W-1:0] right;
    logic [DETAIL_LUT_W-1:0] detail;
    logic                    first;
    logic                    accept;

    assign pix_ready_o = (state == IDLE) || (state == RUN);
    assign accept      = pix_valid_i && pix_ready_o;

    // The right neighbour is the incoming beat, or the centre itself at the line end.
    assign right = (state == FLUSH) ? p_cur : pix_data_i;

`ifdef DETAIL_GRAD_SMOOTH_EN
    logic [PIXEL_DATA_W-1:0] g_last;
    logic [PIXEL_DATA_W-1:0] g_used;
`endif

    detail_quant #(
        .PIXEL_DATA_W (PIXEL_DATA_W),
        .DETAIL_LUT_W (DETAIL_LUT_W),
        .GRAD_SHIFT   (GRAD_SHIFT)
    ) u_quant (
        .a      (right),
        .b      (p_prev),
`ifdef DETAIL_GRAD_SMOOTH_EN
        .g_last (g_last),
        .g_used (g_used),
`endif
        .detail (detail)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            p_prev      <= '0;
            p_cur       <= '0;
            first       <= 1'b0;
            data_lut_o  <= '0;
            lut_valid_o <= 1'b0;
            lut_sol_o   <= 1'b0;
            lut_eol_o   <= 1'b0;
`ifdef DETAIL_GRAD_SMOOTH_EN
            g_last      <= '0;
`endif
        end else begin
            lut_valid_o <= 1'b0;
            lut_sol_o   <= 1'b0;
            lut_eol_o   <= 1'b0;
            // A start-of-line beat always restarts, dropping any unterminated pending pixel.
            if (accept && pix_sol_i) begin
                p_prev <= pix_data_i;
                p_cur  <= pix_data_i;
                first  <= 1'b1;
                state  <= pix_eol_i ? FLUSH : RUN;
`ifdef DETAIL_GRAD_SMOOTH_EN
                g_last <= '0;
`endif
            end else if (accept && (state == RUN)) begin
                data_lut_o  <= {p_cur, detail};
                lut_valid_o <= 1'b1;
                lut_sol_o   <= first;
                p_prev      <= p_cur;
                p_cur       <= pix_data_i;
                first       <= 1'b0;
                state       <= pix_eol_i ? FLUSH : RUN;
`ifdef DETAIL_GRAD_SMOOTH_EN
                g_last      <= g_used;
`endif
            end else if (state == FLUSH) begin
                data_lut_o  <= {p_cur, detail};
                lut_valid_o <= 1'b1;
                lut_sol_o   <= first;
                lut_eol_o   <= 1'b1;
                state       <= IDLE;
`ifdef DETAIL_GRAD_SMOOTH_EN
                g_last      <= g_used;
`endif
            end else if (state != IDLE && state != RUN) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_detail_lut_index.sv
// Scoreboard bench for detail_lut_index: neighbour-based reference model plus fixed vectors.
module tb_detail_lut_index;

    localparam int PW    = 8;
    localparam int DW    = 3;
    localparam int SHIFT = 4;

    typedef struct packed {
        logic [PW+DW-1:0] data;
        logic             sol;
        logic             eol;
    } beat_t;

    typedef struct packed {
        logic [PW-1:0] d;
        logic          sol;
        logic          eol;
    } stim_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_sol = 1'b0;
    logic          pix_eol = 1'b0;
    logic          pix_ready;
    logic [PW+DW-1:0] data_lut;
    logic          lut_valid;
    logic          lut_sol;
    logic          lut_eol;

    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;
    int    glast_m = 0;
    beat_t exp_q[$];
    stim_t stim_q[$];
    int    acc_q[$];

    detail_lut_index #(
        .PIXEL_DATA_W (PW),
        .DETAIL_LUT_W (DW),
        .GRAD_SHIFT   (SHIFT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .pix_data_i  (pix_data),
        .pix_valid_i (pix_valid),
        .pix_sol_i   (pix_sol),
        .pix_eol_i   (pix_eol),
        .pix_ready_o (pix_ready),
        .data_lut_o  (data_lut),
        .lut_valid_o (lut_valid),
        .lut_sol_o   (lut_sol),
        .lut_eol_o   (lut_eol)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic beat_t mk(input int pix, input int det, input bit sol, input bit eol);
        beat_t b;
        b.data = {pix[PW-1:0], det[DW-1:0]};
        b.sol  = sol;
        b.eol  = eol;
        return b;
    endfunction

    // Reference: detail from the true left/right neighbours, edges replicated.
    function automatic void push_expect(input int pix, input int left, input int right,
                                        input bit sol, input bit eol);
        int g;
        int det;
        if (sol) glast_m = 0;
        g = (right > left) ? (right - left) : (left - right);
`ifdef DETAIL_GRAD_SMOOTH_EN
        g = (g + glast_m + 1) / 2;
        glast_m = g;
`endif
        det = g >> SHIFT;
        if (det > (1 << DW) - 1) det = (1 << DW) - 1;
        exp_q.push_back(mk(pix, det, sol, eol));
    endfunction

    function automatic void push_stim(input int d, input bit sol, input bit eol);
        stim_t s;
        s.d   = PW'(d);
        s.sol = sol;
        s.eol = eol;
        stim_q.push_back(s);
    endfunction

    function automatic void add_line(input int px[$]);
        int n;
        int left;
        int right;
        n = px.size();
        for (int i = 0; i < n; i++) begin
            left  = (i == 0) ? px[0] : px[i-1];
            right = (i == n - 1) ? px[n-1] : px[i+1];
            push_expect(px[i], left, right, i == 0, i == n - 1);
            push_stim(px[i], i == 0, i == n - 1);
        end
    endfunction

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send_beat(input stim_t s);
        bit done;
        done      = 1'b0;
        pix_data  = s.d;
        pix_sol   = s.sol;
        pix_eol   = s.eol;
        pix_valid = 1'b1;
        for (int t = 0; t < 10 && !done; t++) begin
            if (pix_ready === 1'b1) begin
                acc_q.push_back(cyc);
                done = 1'b1;
            end
            @(negedge clk);
        end
        pix_valid = 1'b0;
        pix_sol   = 1'b0;
        pix_eol   = 1'b0;
        tests++;
        if (!done) begin
            fails++;
            $display("[TB] FAIL accept_timeout: pixel %0d not accepted, ready=%b required 1", s.d, pix_ready);
        end
    endtask

    task automatic drive_beats(input int gap);
        while (stim_q.size() != 0) begin
            send_beat(stim_q.pop_front());
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_out(input int budget, output beat_t got, output int oc, output bit ok);
        ok  = 1'b0;
        got = '0;
        oc  = 0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (lut_valid === 1'b1) begin
                got = {data_lut, lut_sol, lut_eol};
                oc  = cyc;
                ok  = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({data_lut, lut_valid, lut_sol, lut_eol} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got data=%h v=%b s=%b e=%b, required all 0",
                     data_lut, lut_valid, lut_sol, lut_eol);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (pix_ready !== 1'b1 || lut_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_release: ready=%b valid=%b, required ready=1 valid=0",
                     pix_ready, lut_valid);
        end
    endtask

    task automatic test_line();
        beat_t got, exp;
        int    oc;
        bit    ok;
        int    px[$];
`ifndef DETAIL_GRAD_SMOOTH_EN
        exp_q.push_back(mk(10, 2, 1, 0));
        exp_q.push_back(mk(50, 5, 0, 0));
        exp_q.push_back(mk(90, 1, 0, 0));
        exp_q.push_back(mk(30, 3, 0, 1));
        push_stim(10, 1, 0);
        push_stim(50, 0, 0);
        push_stim(90, 0, 0);
        push_stim(30, 0, 1);
`else
        px = {10, 50, 90, 30};
        add_line(px);
`endif
        fork
            begin
                drive_beats(0);
                tests++;
                if (pix_ready !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL line_flush_ready: ready=%b, required 0", pix_ready);
                end
                @(negedge clk);
                tests++;
                if (pix_ready !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL line_ready_back: ready=%b, required 1", pix_ready);
                end
            end
            begin
                while (exp_q.size() != 0) begin
                    wait_out(20, got, oc, ok);
                    tests++;
                    if (!ok) begin
                        fails++;
                        $display("[TB] FAIL line_beat: no beat, %0d still required", exp_q.size());
                        exp_q.delete();
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            fails++;
                            $display("[TB] FAIL line_beat: got pix=%0d det=%0d s=%b e=%b, required pix=%0d det=%0d s=%b e=%b",
                                     got.data[PW+DW-1:DW], got.data[DW-1:0], got.sol, got.eol,
                                     exp.data[PW+DW-1:DW], exp.data[DW-1:0], exp.sol, exp.eol);
                        end
                    end
                end
            end
        join
        wait_out(4, got, oc, ok);
        tests++;
        if (ok) begin
            fails++;
            $display("[TB] FAIL line_extra: got beat pix=%0d, required none", got.data[PW+DW-1:DW]);
        end
    endtask

    task automatic test_single();
        beat_t got, exp;
        int    oc;
        bit    ok;
        acc_q.delete();
        exp_q.push_back(mk(200, 0, 1, 1));
        push_stim(200, 1, 1);
        fork
            drive_beats(0);
            begin
                wait_out(20, got, oc, ok);
                exp = exp_q.pop_front();
                tests++;
                if (!ok || got !== exp) begin
                    fails++;
                    $display("[TB] FAIL single_beat: ok=%b got pix=%0d det=%0d s=%b e=%b, required pix=200 det=0 s=1 e=1",
                             ok, got.data[PW+DW-1:DW], got.data[DW-1:0], got.sol, got.eol);
                end
                tests++;
                if (!ok || acc_q.size() != 1 || oc - acc_q[0] != 2) begin
                    fails++;
                    $display("[TB] FAIL single_latency: got out cycle %0d, required acceptance+2", oc);
                end
            end
        join
        wait_out(4, got, oc, ok);
        tests++;
        if (ok) begin
            fails++;
            $display("[TB] FAIL single_extra: got beat pix=%0d, required none", got.data[PW+DW-1:DW]);
        end
    endtask

    task automatic test_saturation();
        beat_t got, exp;
        int    oc;
        bit    ok;
        int    px[$];
        px = {0, 255, 0};
        add_line(px);
        fork
            drive_beats(0);
            begin
                while (exp_q.size() != 0) begin
                    wait_out(20, got, oc, ok);
                    tests++;
                    if (!ok) begin
                        fails++;
                        $display("[TB] FAIL sat_beat: no beat, %0d still required", exp_q.size());
                        exp_q.delete();
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            fails++;
                            $display("[TB] FAIL sat_beat: got pix=%0d det=%0d s=%b e=%b, required pix=%0d det=%0d s=%b e=%b",
                                     got.data[PW+DW-1:DW], got.data[DW-1:0], got.sol, got.eol,
                                     exp.data[PW+DW-1:DW], exp.data[DW-1:0], exp.sol, exp.eol);
                        end
                    end
                end
            end
        join
    endtask

    task automatic test_gaps();
        beat_t got, exp;
        int    oc;
        bit    ok;
        int    px[$];
        int    oc_q[$];
        int    want;
        acc_q.delete();
        px = {10, 50, 90, 30};
        add_line(px);
        fork
            drive_beats(2);
            begin
                while (exp_q.size() != 0) begin
                    wait_out(20, got, oc, ok);
                    tests++;
                    if (!ok) begin
                        fails++;
                        $display("[TB] FAIL gap_beat: no beat, %0d still required", exp_q.size());
                        exp_q.delete();
                    end else begin
                        oc_q.push_back(oc);
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            fails++;
                            $display("[TB] FAIL gap_beat: got pix=%0d det=%0d s=%b e=%b, required pix=%0d det=%0d s=%b e=%b",
                                     got.data[PW+DW-1:DW], got.data[DW-1:0], got.sol, got.eol,
                                     exp.data[PW+DW-1:DW], exp.data[DW-1:0], exp.sol, exp.eol);
                        end
                    end
                end
            end
        join
        tests++;
        if (oc_q.size() != 4 || acc_q.size() != 4) begin
            fails++;
            $display("[TB] FAIL gap_count: got %0d beats %0d accepts, required 4 and 4", oc_q.size(), acc_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                want = (i < 3) ? acc_q[i+1] + 1 : acc_q[3] + 2;
                tests++;
                if (oc_q[i] != want) begin
                    fails++;
                    $display("[TB] FAIL gap_latency: beat %0d at cycle %0d, required %0d", i, oc_q[i], want);
                end
            end
        end
    endtask

    task automatic test_drop_restart();
        beat_t got, exp;
        int    oc;
        bit    ok;
        push_stim(5, 0, 0);
        push_stim(6, 0, 1);
        push_stim(10, 1, 0);
        push_stim(20, 0, 0);
        push_stim(100, 1, 0);
        push_stim(100, 0, 1);
        push_expect(10, 10, 20, 1, 0);
        push_expect(100, 100, 100, 1, 0);
        push_expect(100, 100, 100, 0, 1);
        fork
            drive_beats(0);
            begin
                while (exp_q.size() != 0) begin
                    wait_out(20, got, oc, ok);
                    tests++;
                    if (!ok) begin
                        fails++;
                        $display("[TB] FAIL drop_beat: no beat, %0d still required", exp_q.size());
                        exp_q.delete();
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            fails++;
                            $display("[TB] FAIL drop_beat: got pix=%0d det=%0d s=%b e=%b, required pix=%0d det=%0d s=%b e=%b",
                                     got.data[PW+DW-1:DW], got.data[DW-1:0], got.sol, got.eol,
                                     exp.data[PW+DW-1:DW], exp.data[DW-1:0], exp.sol, exp.eol);
                        end
                    end
                end
            end
        join
        wait_out(4, got, oc, ok);
        tests++;
        if (ok) begin
            fails++;
            $display("[TB] FAIL drop_extra: got beat pix=%0d, required none", got.data[PW+DW-1:DW]);
        end
    endtask

    task automatic test_reset_midline();
        beat_t got, exp;
        int    oc;
        bit    ok;
        push_stim(10, 1, 0);
        push_stim(50, 0, 0);
        push_stim(90, 0, 0);
        push_expect(10, 10, 50, 1, 0);
        push_expect(50, 10, 90, 0, 0);
        fork
            drive_beats(0);
            begin
                while (exp_q.size() != 0) begin
                    wait_out(20, got, oc, ok);
                    tests++;
                    if (!ok) begin
                        fails++;
                        $display("[TB] FAIL midrst_beat: no beat, %0d still required", exp_q.size());
                        exp_q.delete();
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            fails++;
                            $display("[TB] FAIL midrst_beat: got pix=%0d det=%0d s=%b e=%b, required pix=%0d det=%0d s=%b e=%b",
                                     got.data[PW+DW-1:DW], got.data[DW-1:0], got.sol, got.eol,
                                     exp.data[PW+DW-1:DW], exp.data[DW-1:0], exp.sol, exp.eol);
                        end
                    end
                end
            end
        join
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({data_lut, lut_valid, lut_sol, lut_eol} !== '0 || pix_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midrst_outputs: got data=%h v=%b s=%b e=%b rdy=%b, required zeros and rdy=1",
                     data_lut, lut_valid, lut_sol, lut_eol, pix_ready);
        end
        rst = 1'b0;
        wait_out(6, got, oc, ok);
        tests++;
        if (ok) begin
            fails++;
            $display("[TB] FAIL midrst_flush: got beat pix=%0d, required none", got.data[PW+DW-1:DW]);
        end
    endtask

    task automatic test_back_to_back();
        beat_t got, exp;
        int    oc;
        bit    ok;
        int    px[$];
        int    n;
        for (int l = 0; l < 4; l++) begin
            px.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) px.push_back(int'($urandom_range(0, 255)));
            add_line(px);
        end
        fork
            drive_beats(0);
            begin
                while (exp_q.size() != 0) begin
                    wait_out(20, got, oc, ok);
                    tests++;
                    if (!ok) begin
                        fails++;
                        $display("[TB] FAIL b2b_beat: no beat, %0d still required", exp_q.size());
                        exp_q.delete();
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            fails++;
                            $display("[TB] FAIL b2b_beat: got pix=%0d det=%0d s=%b e=%b, required pix=%0d det=%0d s=%b e=%b",
                                     got.data[PW+DW-1:DW], got.data[DW-1:0], got.sol, got.eol,
                                     exp.data[PW+DW-1:DW], exp.data[DW-1:0], exp.sol, exp.eol);
                        end
                    end
                end
            end
        join
        wait_out(4, got, oc, ok);
        tests++;
        if (ok) begin
            fails++;
            $display("[TB] FAIL b2b_extra: got beat pix=%0d, required none", got.data[PW+DW-1:DW]);
        end
    endtask

`ifdef DETAIL_GRAD_SMOOTH_EN
    task automatic test_smooth();
        beat_t got, exp;
        int    oc;
        bit    ok;
        push_stim(0, 1, 0);
        push_stim(0, 0, 0);
        push_stim(64, 0, 1);
        exp_q.push_back(mk(0, 0, 1, 0));
        exp_q.push_back(mk(0, 2, 0, 0));
        exp_q.push_back(mk(64, 3, 0, 1));
        fork
            drive_beats(0);
            begin
                while (exp_q.size() != 0) begin
                    wait_out(20, got, oc, ok);
                    tests++;
                    if (!ok) begin
                        fails++;
                        $display("[TB] FAIL smooth_beat: no beat, %0d still required", exp_q.size());
                        exp_q.delete();
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            fails++;
                            $display("[TB] FAIL smooth_beat: got pix=%0d det=%0d s=%b e=%b, required pix=%0d det=%0d s=%b e=%b",
                                     got.data[PW+DW-1:DW], got.data[DW-1:0], got.sol, got.eol,
                                     exp.data[PW+DW-1:DW], exp.data[DW-1:0], exp.sol, exp.eol);
                        end
                    end
                end
            end
        join
    endtask
`endif

    initial begin
        test_reset();
        test_line();
        test_single();
        test_saturation();
        test_gaps();
        test_drop_restart();
        test_reset_midline();
        test_back_to_back();
`ifdef DETAIL_GRAD_SMOOTH_EN
        test_smooth();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
